// File: rtl/sevenseg_scan_driver_if.sv
// Interface for the 7-segment driver: load handshake, direction switch and SEG/AN pins.
// The master loads values and reads the display pins; the slave is the driver block.
interface sevenseg_scan_driver_if #(
  parameter int N_DIGITS = 4,
  parameter int VAL_W    = 12
);
  logic [VAL_W-1:0]    value_in;
  logic                load;
  logic                busy;
  logic                dir_in;
  logic                ovf;
  logic [6:0]          SEG;
  logic [N_DIGITS-1:0] AN;

  modport master (
    output value_in, load, dir_in,
    input  busy, ovf, SEG, AN
  );

  modport slave (
    input  value_in, load, dir_in,
    output busy, ovf, SEG, AN
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed 7-segment driver: serial double-dabble BCD conversion (VAL_W+1 cycles load to commit,
// load ignored while busy), then guarded anode scanning with glyph, blanking and overflow dashes.
module sevenseg_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int VAL_W    = 12,
  parameter int SCAN_DIV = 262144,
  parameter int GUARD    = 64,
  parameter int GLYPH_EN = 1,
  parameter int BLANK_LZ = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sevenseg_scan_driver_if.slave   bus
);

  localparam int D     = N_DIGITS - GLYPH_EN;
  localparam int BCD_W = 4 * D;
  localparam int TOT_W = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

  localparam logic [31:0] LIMIT = pow10(D);

  function automatic logic [6:0] dec7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } state_e;

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [TOT_W-1:0]   shifted;

  logic [PS_W-1:0]     presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                dir_meta_q, dir_sync_q;

  logic [3:0]          cur_nib;
  logic                upper_nz;

  // One double-dabble step: correct every nibble >=5, then shift the whole chain left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < D; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          bin_d   = bus.value_in;
          bcd_d   = '0;
          cnt_d   = '0;
          pend_d  = (32'(bus.value_in) >= LIMIT);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d = shifted[TOT_W-1:VAL_W];
        bin_d = shifted[VAL_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VAL_W - 1)) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        disp_d  = bcd_q;
        ovf_d   = pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    presc_d = presc_q + PS_W'(1);
    idx_d   = idx_q;
    if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // upper_nz: any nonzero nibble at or above the digit being scanned.
  always_comb begin
    cur_nib  = 4'd0;
    upper_nz = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (i == int'(idx_q)) begin
        cur_nib = disp_q[4*i +: 4];
      end
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) begin
        upper_nz = 1'b1;
      end
    end
  end

  always_comb begin
    if (presc_q < PS_W'(GUARD)) begin
      an_d = '1;
    end else begin
      an_d = ~(N_DIGITS'(1) << idx_q);
    end

    if (GLYPH_EN != 0 && idx_q == IDX_W'(N_DIGITS - 1)) begin
      seg_d = dir_sync_q ? 7'b0101111 : 7'b0001110;
    end else if (ovf_q) begin
      seg_d = 7'b0111111;
    end else if (BLANK_LZ != 0 && idx_q != '0 && !upper_nz) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = dec7(cur_nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      seg_q      <= 7'h7F;
      an_q       <= '1;
      dir_meta_q <= 1'b0;
      dir_sync_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      dir_meta_q <= bus.dir_in;
      dir_sync_q <= dir_meta_q;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.ovf  = ovf_q;
  assign bus.SEG  = seg_q;
  assign bus.AN   = an_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with a short scan period; display expectations come from
// decimal arithmetic on the loaded value, scan position from a cycle count since reset release.
module tb_sevenseg_scan_driver;
  localparam int N  = 4;
  localparam int VW = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_driver_if #(.N_DIGITS(N), .VAL_W(VW)) bus ();

  sevenseg_scan_driver #(
    .N_DIGITS(N), .VAL_W(VW), .SCAN_DIV(8), .GUARD(2), .GLYPH_EN(1), .BLANK_LZ(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  int k;
  int m_val;
  bit m_ovf;
  bit m_dir;

  // Posedges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic [6:0] dec(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {AN, SEG} after kk edges; outputs lag the scan position by one cycle.
  function automatic logic [10:0] exp_out(input int kk);
    logic [3:0] an;
    logic [6:0] seg;
    int p, idx, pw;
    if (kk == 0) return {4'hF, 7'h7F};
    p   = kk - 1;
    idx = (p / 8) % 4;
    if (p % 8 < 2) return {4'hF, 7'h7F};
    an      = 4'hF;
    an[idx] = 1'b0;
    pw = 1;
    for (int i = 0; i < idx; i++) pw = pw * 10;
    if (idx == 3)                        seg = m_dir ? 7'b0101111 : 7'b0001110;
    else if (m_ovf)                      seg = 7'b0111111;
    else if (idx != 0 && m_val < pw)     seg = 7'h7F;
    else                                 seg = dec((m_val / pw) % 10);
    return {an, seg};
  endfunction

  task automatic drive_load(input int v);
    @(negedge clk);
    bus.value_in = VW'(v);
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load     = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [10:0] e;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.value_in = '0;
    bus.dir_in = 1'b0;
    #23;
    checks++; if (bus.SEG !== 7'h7F) begin fails++; $display("FAIL reset_seg got %b want 1111111", bus.SEG); end
    checks++; if (bus.AN !== 4'hF)   begin fails++; $display("FAIL reset_an got %h want f", bus.AN); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0)  begin fails++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    m_val = 0; m_ovf = 0; m_dir = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_reset k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_convert_987;
    logic [10:0] e;
    int n;
    drive_load(987);
    n = 0;
    // Display must keep the old value for the whole conversion.
    while (bus.busy === 1'b1 && n < 100) begin
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL hold_987 k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
      n++;
      @(negedge clk);
    end
    checks++; if (n != 13)          begin fails++; $display("FAIL busy_987 got %0d cycles want 13", n); end
    checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_987 got %b want 0", bus.ovf); end
    m_val = 987; m_ovf = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_987 k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [10:0] e;
    int n;
    drive_load(1500);
    count_busy(n);
    checks++; if (n != 13)          begin fails++; $display("FAIL busy_1500 got %0d cycles want 13", n); end
    checks++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_1500 got %b want 1", bus.ovf); end
    m_val = 1500; m_ovf = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_1500 k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_ignore_while_busy;
    logic [10:0] e;
    int n, extra;
    drive_load(5);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      if ((n >= 2 && n < 6) || n == 12) begin
        bus.value_in = VW'(42);
        bus.load     = 1'b1;
      end else begin
        bus.load     = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    bus.load = 1'b0;
    checks++; if (n != 13) begin fails++; $display("FAIL busy_5 got %0d cycles want 13", n); end
    extra = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.busy !== 1'b0) extra++;
      @(negedge clk);
    end
    checks++; if (extra != 0)       begin fails++; $display("FAIL no_queue busy seen %0d cycles want 0", extra); end
    checks++; if (bus.ovf !== 1'b0) begin fails++; $display("FAIL ovf_5 got %b want 0", bus.ovf); end
    m_val = 5; m_ovf = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_5 k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_dir;
    logic [10:0] e;
    @(negedge clk);
    bus.dir_in = 1'b1;
    m_dir = 1;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_dir k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
  endtask

  task automatic test_random;
    logic [10:0] e;
    int n, v, sel;
    for (int it = 0; it < 10; it++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      v = int'($urandom_range(0, 4095));
      else if (sel == 1) v = int'($urandom_range(0, 999));
      else               v = int'($urandom_range(0, 99));
      @(negedge clk);
      bus.dir_in = $urandom_range(0, 1) == 1;
      m_dir = bus.dir_in;
      drive_load(v);
      count_busy(n);
      checks++; if (n != 13) begin fails++; $display("FAIL busy_rand v=%0d got %0d cycles want 13", v, n); end
      m_val = v;
      m_ovf = (v >= 1000);
      checks++;
      if (bus.ovf !== m_ovf) begin fails++; $display("FAIL ovf_rand v=%0d got %b want %b", v, bus.ovf, m_ovf); end
      for (int c = 0; c < 36; c++) begin
        @(negedge clk);
        e = exp_out(k);
        checks++;
        if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
          fails++;
          $display("FAIL scan_rand v=%0d k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", v, k, bus.AN, bus.SEG, e[10:7], e[6:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift;
    logic [10:0] e;
    int n;
    drive_load(2500);
    count_busy(n);
    checks++; if (bus.ovf !== 1'b1) begin fails++; $display("FAIL ovf_pre_reset got %b want 1", bus.ovf); end
    drive_load(777);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.SEG !== 7'h7F) begin fails++; $display("FAIL midrst_seg got %b want 1111111", bus.SEG); end
    checks++; if (bus.AN !== 4'hF)   begin fails++; $display("FAIL midrst_an got %h want f", bus.AN); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0)  begin fails++; $display("FAIL midrst_ovf got %b want 0", bus.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    m_val = 0; m_ovf = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      e = exp_out(k);
      checks++;
      if (bus.AN !== e[10:7] || (e[10:7] != 4'hF && bus.SEG !== e[6:0])) begin
        fails++;
        $display("FAIL scan_midrst k=%0d got AN=%h SEG=%b want AN=%h SEG=%b", k, bus.AN, bus.SEG, e[10:7], e[6:0]);
      end
    end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.load     = 1'b0;
    bus.value_in = '0;
    bus.dir_in   = 1'b0;
    test_reset();
    test_convert_987();
    test_overflow();
    test_ignore_while_busy();
    test_dir();
    test_random();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
